// File: rtl/sa_wavefront_sel_seq_if.sv
// Handshake and element bus between a pass requester and the wavefront sequencer.
// The requester drives start/mode/stall; the sequencer drives the walk outputs.
interface sa_wavefront_sel_seq_if #(
    parameter int SEL_W  = 2,
    parameter int DIAG_W = 3,
    parameter int CNT_W  = 4
);
    logic              start;
    logic              mode;
    logic              stall;
    logic              busy;
    logic              valid;
    logic [SEL_W-1:0]  sel;
    logic [SEL_W-1:0]  col;
    logic [DIAG_W-1:0] diag;
    logic [CNT_W-1:0]  cnt;
    logic              diag_last;
    logic              done;

    modport master (
        output start, mode, stall,
        input  busy, valid, sel, col, diag, cnt, diag_last, done
    );

    modport slave (
        input  start, mode, stall,
        output busy, valid, sel, col, diag, cnt, diag_last, done
    );
endinterface

// File: rtl/sa_wavefront_sel_seq.sv
// Anti-diagonal wavefront walker for an N x N systolic array input stage.
// Emits one (row, col, diag) element per cycle, forward or time-reversed.
module sa_wavefront_sel_seq #(
    parameter int N      = 3,
    parameter int SEL_W  = 2,
    parameter int DIAG_W = 3,
    parameter int CNT_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    sa_wavefront_sel_seq_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N * N - 1);

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              diag_last_q, diag_last_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  col_q, col_d;
    logic [DIAG_W-1:0] diag_q, diag_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic load;
    logic elem_mode;
    int   cur_d, cur_r, nxt_d, nxt_r;

    // Row bounds of diagonal d inside the N x N array.
    function automatic int lo_r(input int d);
        return (d > N - 1) ? d - (N - 1) : 0;
    endfunction

    function automatic int hi_r(input int d);
        return (d < N - 1) ? d : N - 1;
    endfunction

    function automatic logic last_of(input int d, input int r, input logic m);
        return m ? (r == lo_r(d)) : (r == hi_r(d));
    endfunction

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        busy_d      = busy_q;
        valid_d     = valid_q;
        done_d      = 1'b0;
        diag_last_d = diag_last_q;
        sel_d       = sel_q;
        col_d       = col_q;
        diag_d      = diag_q;
        cnt_d       = cnt_q;
        load        = 1'b0;
        elem_mode   = mode_q;
        cur_d       = int'(diag_q);
        cur_r       = int'(sel_q);
        nxt_d       = cur_d;
        nxt_r       = cur_r;

        case (state_q)
            RUN: begin
                if (!bus.stall) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d     = FIN;
                        busy_d      = 1'b0;
                        valid_d     = 1'b0;
                        done_d      = 1'b1;
                        diag_last_d = 1'b0;
                        sel_d       = '0;
                        col_d       = '0;
                        diag_d      = '0;
                        cnt_d       = '0;
                    end else begin
                        // Step within the diagonal, or jump to the start of the next one.
                        if (!mode_q) begin
                            if (cur_r < hi_r(cur_d)) begin
                                nxt_r = cur_r + 1;
                            end else begin
                                nxt_d = cur_d + 1;
                                nxt_r = lo_r(cur_d + 1);
                            end
                        end else begin
                            if (cur_r > lo_r(cur_d)) begin
                                nxt_r = cur_r - 1;
                            end else begin
                                nxt_d = cur_d - 1;
                                nxt_r = hi_r(cur_d - 1);
                            end
                        end
                        cnt_d = cnt_q + CNT_W'(1);
                        load  = 1'b1;
                    end
                end
            end
            default: begin
                // IDLE and FIN both accept start, which gives back-to-back passes.
                if (bus.start) begin
                    state_d   = RUN;
                    mode_d    = bus.mode;
                    elem_mode = bus.mode;
                    busy_d    = 1'b1;
                    valid_d   = 1'b1;
                    cnt_d     = '0;
                    nxt_d     = bus.mode ? 2 * N - 2 : 0;
                    nxt_r     = bus.mode ? N - 1 : 0;
                    load      = 1'b1;
                end else begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    valid_d     = 1'b0;
                    diag_last_d = 1'b0;
                    sel_d       = '0;
                    col_d       = '0;
                    diag_d      = '0;
                    cnt_d       = '0;
                end
            end
        endcase

        if (load) begin
            sel_d       = SEL_W'(nxt_r);
            col_d       = SEL_W'(nxt_d - nxt_r);
            diag_d      = DIAG_W'(nxt_d);
            diag_last_d = last_of(nxt_d, nxt_r, elem_mode);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            diag_last_q <= 1'b0;
            sel_q       <= '0;
            col_q       <= '0;
            diag_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            diag_last_q <= diag_last_d;
            sel_q       <= sel_d;
            col_q       <= col_d;
            diag_q      <= diag_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.valid     = valid_q;
    assign bus.done      = done_q;
    assign bus.diag_last = diag_last_q;
    assign bus.sel       = sel_q;
    assign bus.col       = col_q;
    assign bus.diag      = diag_q;
    assign bus.cnt       = cnt_q;
endmodule

// File: tb/tb_sa_wavefront_sel_seq.sv
// Directed bench for the wavefront sequencer: N=3 in both orders, stall, abort,
// back-to-back passes, and an N=4 forward walk.
module tb_sa_wavefront_sel_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sa_wavefront_sel_seq_if #(.SEL_W(2), .DIAG_W(3), .CNT_W(4)) if3 ();
    sa_wavefront_sel_seq_if #(.SEL_W(2), .DIAG_W(3), .CNT_W(4)) if4 ();

    sa_wavefront_sel_seq #(.N(3), .SEL_W(2), .DIAG_W(3), .CNT_W(4)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3)
    );

    sa_wavefront_sel_seq #(.N(4), .SEL_W(2), .DIAG_W(3), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    // Hand-computed N=3 walks.
    int fsel  [9] = '{0, 0, 1, 0, 1, 2, 1, 2, 2};
    int fcol  [9] = '{0, 1, 0, 2, 1, 0, 2, 1, 2};
    int fdiag [9] = '{0, 1, 1, 2, 2, 2, 3, 3, 4};
    int rsel  [9] = '{2, 2, 1, 2, 1, 0, 1, 0, 0};
    int rcol  [9] = '{2, 1, 2, 0, 1, 2, 0, 1, 0};
    int rdiag [9] = '{4, 3, 3, 2, 2, 2, 1, 1, 0};
    int last3 [9] = '{1, 0, 1, 0, 0, 1, 0, 1, 1};

    // Hand-computed N=4 forward walk.
    int sel4  [16] = '{0, 0, 1, 0, 1, 2, 0, 1, 2, 3, 1, 2, 3, 2, 3, 3};
    int col4  [16] = '{0, 1, 0, 2, 1, 0, 3, 2, 1, 0, 3, 2, 1, 3, 2, 3};
    int diag4 [16] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3, 4, 4, 4, 5, 5, 6};
    int last4 [16] = '{1, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 1, 1};

    // Stall scenario: element index shown on each valid cycle.
    int sidx  [12] = '{0, 1, 2, 3, 4, 4, 4, 4, 5, 6, 7, 8};

    // Packed view: {valid, busy, sel, col, diag, cnt, diag_last, done}.
    function automatic logic [14:0] pk(input logic v, input logic b, input int s, input int c,
                                       input int d, input int n, input logic l, input logic dn);
        return {v, b, 2'(s), 2'(c), 3'(d), 4'(n), l, dn};
    endfunction

    function automatic logic [14:0] obs3();
        return {if3.valid, if3.busy, if3.sel, if3.col, if3.diag, if3.cnt, if3.diag_last, if3.done};
    endfunction

    function automatic logic [14:0] obs4();
        return {if4.valid, if4.busy, if4.sel, if4.col, if4.diag, if4.cnt, if4.diag_last, if4.done};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [14:0] o, e;
        rst = 1'b1;
        step();
        step();
        e = pk(0, 0, 0, 0, 0, 0, 0, 0);
        o = obs3();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL reset_n3 got=%h exp=%h", o, e);
        end
        o = obs4();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL reset_n4 got=%h exp=%h", o, e);
        end
        rst = 1'b0;
        if3.stall = 1'b1;
        step();
        o = obs3();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL idle_stall got=%h exp=%h", o, e);
        end
        if3.stall = 1'b0;
    endtask

    task automatic test_forward();
        logic [14:0] o, e;
        if3.start = 1'b1;
        if3.mode  = 1'b0;
        step();
        if3.start = 1'b0;
        if3.mode  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            e = pk(1, 1, fsel[i], fcol[i], fdiag[i], i, last3[i] != 0, 0);
            o = obs3();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL fwd[%0d] got=%h exp=%h", i, o, e);
            end
            step();
        end
        e = pk(0, 0, 0, 0, 0, 0, 0, 1);
        o = obs3();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL fwd_done got=%h exp=%h", o, e);
        end
        step();
        e = pk(0, 0, 0, 0, 0, 0, 0, 0);
        o = obs3();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL fwd_idle got=%h exp=%h", o, e);
        end
    endtask

    task automatic test_reverse();
        logic [14:0] o, e;
        int dones = 0;
        if3.start = 1'b1;
        if3.mode  = 1'b1;
        step();
        if3.start = 1'b0;
        if3.mode  = 1'b0;
        for (int i = 0; i < 9; i++) begin
            e = pk(1, 1, rsel[i], rcol[i], rdiag[i], i, last3[i] != 0, 0);
            o = obs3();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL rev[%0d] got=%h exp=%h", i, o, e);
            end
            step();
        end
        e = pk(0, 0, 0, 0, 0, 0, 0, 1);
        o = obs3();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL rev_done got=%h exp=%h", o, e);
        end
        for (int k = 0; k < 4; k++) begin
            if (if3.done === 1'b1) dones++;
            step();
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL rev_done_pulses got=%0d exp=1", dones);
        end
    endtask

    task automatic test_stall();
        logic [14:0] o, e;
        if3.start = 1'b1;
        if3.mode  = 1'b0;
        step();
        if3.start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            int i;
            i = sidx[k];
            e = pk(1, 1, fsel[i], fcol[i], fdiag[i], i, last3[i] != 0, 0);
            o = obs3();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL stall[%0d] got=%h exp=%h", k, o, e);
            end
            if3.stall = (k >= 4 && k <= 6);
            step();
        end
        if3.stall = 1'b0;
        e = pk(0, 0, 0, 0, 0, 0, 0, 1);
        o = obs3();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL stall_done got=%h exp=%h", o, e);
        end
        step();
    endtask

    task automatic test_abort();
        logic [14:0] o, e;
        bit seen = 0;
        if3.start = 1'b1;
        if3.mode  = 1'b0;
        step();
        if3.start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        e = pk(1, 1, fsel[5], fcol[5], fdiag[5], 5, 1, 0);
        o = obs3();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL abort_pre got=%h exp=%h", o, e);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        e = pk(0, 0, 0, 0, 0, 0, 0, 0);
        o = obs3();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL abort_rst got=%h exp=%h", o, e);
        end
        step();
        o = obs3();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL abort_no_done got=%h exp=%h", o, e);
        end
        if3.start = 1'b1;
        step();
        if3.start = 1'b0;
        e = pk(1, 1, 0, 0, 0, 0, 1, 0);
        o = obs3();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL abort_restart got=%h exp=%h", o, e);
        end
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            if (if3.done === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL abort_pass_done got=0 exp=1");
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [14:0] o, e;
        bit seen = 0;
        if3.start = 1'b1;
        if3.mode  = 1'b0;
        step();
        for (int i = 0; i < 9; i++) begin
            e = pk(1, 1, fsel[i], fcol[i], fdiag[i], i, last3[i] != 0, 0);
            o = obs3();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL b2b[%0d] got=%h exp=%h", i, o, e);
            end
            if3.start = (i == 2 || i == 3);
            step();
        end
        e = pk(0, 0, 0, 0, 0, 0, 0, 1);
        o = obs3();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL b2b_done got=%h exp=%h", o, e);
        end
        if3.start = 1'b1;
        step();
        if3.start = 1'b0;
        e = pk(1, 1, 0, 0, 0, 0, 1, 0);
        o = obs3();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL b2b_restart got=%h exp=%h", o, e);
        end
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            if (if3.done === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL b2b_second_done got=0 exp=1");
        end
        step();
    endtask

    task automatic test_n4();
        logic [14:0] o, e;
        int lasts = 0;
        if4.start = 1'b1;
        if4.mode  = 1'b0;
        step();
        if4.start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            e = pk(1, 1, sel4[i], col4[i], diag4[i], i, last4[i] != 0, 0);
            o = obs4();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL n4[%0d] got=%h exp=%h", i, o, e);
            end
            if (if4.diag_last === 1'b1) lasts++;
            step();
        end
        e = pk(0, 0, 0, 0, 0, 0, 0, 1);
        o = obs4();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL n4_done got=%h exp=%h", o, e);
        end
        checks++;
        if (lasts != 7) begin
            failures++;
            $display("FAIL n4_diag_last_count got=%0d exp=7", lasts);
        end
        step();
    endtask

    initial begin
        if3.start = 1'b0;
        if3.mode  = 1'b0;
        if3.stall = 1'b0;
        if4.start = 1'b0;
        if4.mode  = 1'b0;
        if4.stall = 1'b0;
        test_reset();
        test_forward();
        test_reverse();
        test_stall();
        test_abort();
        test_back_to_back();
        test_n4();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
